uart_tx_sequencer: RTL

UART_TX_SEQUENCER -- requirements
Module: uart_tx_sequencer

---
 rtl/uart_tx_sequencer.sv | 124 ++++++++++++
 1 files changed

// File: rtl/uart_tx_sequencer.sv
// Word FIFO plus byte sequencer that feeds a byte-wide UART transmitter, LSB byte first.
// Optional macro WORD_TERMINATOR_EN appends a 0x0A byte after every word.
module uart_tx_sequencer #(
    parameter int WORD_LENGTH = 32,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   word_valid,
    input  logic [WORD_LENGTH-1:0] word_data,
    output logic                   word_ready,
    input  logic                   tx_done,
    output logic                   tx_start,
    output logic [7:0]             tx_data,
    output logic                   busy,
    output logic                   overflow
);

    localparam int NBYTES = WORD_LENGTH / 8;
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int CW     = $clog2(NBYTES + 1);

    localparam logic [AW:0]   PTR_ONE   = (AW+1)'(1);
    localparam logic [AW:0]   FULL_CNT  = (AW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] LAST_BYTE = CW'(NBYTES - 1);

`ifdef WORD_TERMINATOR_EN
    typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT, TERM} state_t;
`else
    typedef enum logic [1:0] {IDLE, LOAD, SEND, WAIT} state_t;
`endif

    state_t                 state_q, state_d;
    logic [WORD_LENGTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW:0]            wr_ptr_q, rd_ptr_q, fill, fill_d;
    logic [WORD_LENGTH-1:0] shift_q, shift_d;
    logic [CW-1:0]          byte_cnt_q, byte_cnt_d;
    logic                   word_ready_q, overflow_q;
    logic                   push, pop, empty;

    // Pointers carry one extra bit so full and empty are distinguishable.
    assign fill  = wr_ptr_q - rd_ptr_q;
    assign empty = (fill == '0);
    assign push  = word_valid && word_ready_q;
    assign pop   = (state_q == IDLE) && !empty;

    always_comb begin
        fill_d = fill;
        if (push) fill_d = fill_d + PTR_ONE;
        if (pop)  fill_d = fill_d - PTR_ONE;
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= word_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            word_ready_q <= 1'b1;
            overflow_q   <= 1'b0;
            state_q      <= IDLE;
            shift_q      <= '0;
            byte_cnt_q   <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            word_ready_q <= (fill_d != FULL_CNT);
            overflow_q   <= overflow_q | (word_valid & ~word_ready_q);
            state_q      <= state_d;
            shift_q      <= shift_d;
            byte_cnt_q   <= byte_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        byte_cnt_d = byte_cnt_q;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    state_d    = LOAD;
                    shift_d    = mem_q[rd_ptr_q[AW-1:0]];
                    byte_cnt_d = '0;
                end
            end
            LOAD: state_d = SEND;
            SEND: state_d = WAIT;
            WAIT: begin
                if (tx_done) begin
                    if (byte_cnt_q < LAST_BYTE) begin
                        byte_cnt_d = byte_cnt_q + CW'(1);
                        shift_d    = shift_q >> 8;
                        state_d    = SEND;
                    end
`ifdef WORD_TERMINATOR_EN
                    // byte_cnt = NBYTES marks the terminator frame in WAIT.
                    else if (byte_cnt_q == LAST_BYTE) begin
                        byte_cnt_d = CW'(NBYTES);
                        shift_d    = WORD_LENGTH'(8'h0A);
                        state_d    = TERM;
                    end
`endif
                    else begin
                        state_d = IDLE;
                    end
                end
            end
`ifdef WORD_TERMINATOR_EN
            TERM: state_d = SEND;
`endif
            default: state_d = IDLE;
        endcase
    end

    assign tx_start   = (state_q == SEND);
    assign tx_data    = shift_q[7:0];
    assign busy       = (state_q != IDLE) || !empty;
    assign word_ready = word_ready_q;
    assign overflow   = overflow_q;

endmodule
